// File: rtl/multicycle_pkg.sv
// ============================================================================
// Module : multicycle_pkg
// Brief  : State encodings, opcode constants and control-field codes for the
//          multicycle MIPS control FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] c_SRCB_B      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
// Module : mc_output_decode
// Brief  : State -> control-word decode; write enables and MemRead are masked
//          while reset is asserted.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_output_decode
    import multicycle_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    input  logic   i_rst,
    output ctrl_t  o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_FOUR;
                w_ctrl.alu_op    = c_ALUOP_ADD;
                w_ctrl.pc_src    = c_PCSRC_ALU;
                w_ctrl.ir_write  = i_mem_ready;
                w_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = c_SRCB_IMMSH2;
                w_ctrl.alu_op    = c_ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_IMM;
                w_ctrl.alu_op    = c_ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctrl.iord     = 1'b1;
                w_ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_B;
                w_ctrl.alu_op    = c_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = c_SRCB_B;
                w_ctrl.alu_op    = c_ALUOP_SUB;
                w_ctrl.pc_src    = c_PCSRC_ALUOUT;
                w_ctrl.branch    = 1'b1;
            end
            S_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_src   = c_PCSRC_JUMP;
                w_ctrl.pc_write = 1'b1;
            end
            default: w_ctrl = '0;
        endcase

        // Nothing may touch architectural state while reset is held.
        if (i_rst) begin
            w_ctrl.ir_write  = 1'b0;
            w_ctrl.pc_write  = 1'b0;
            w_ctrl.mem_write = 1'b0;
            w_ctrl.reg_write = 1'b0;
            w_ctrl.branch    = 1'b0;
            w_ctrl.mem_read  = 1'b0;
        end
    end

    assign o_ctrl = w_ctrl;

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Main control FSM for the multicycle MIPS datapath; state register,
//          next-state logic and sticky illegal-opcode flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [OP_W-1:0]    Op,
    input  logic               MemReady,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSrc,
    output logic               PCWrite,
    output logic               Branch,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] StateOut
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_op_known;
    ctrl_t  w_ctrl;

    assign w_op_known = (Op == OP_W'(c_OP_LW))    || (Op == OP_W'(c_OP_SW))   ||
                        (Op == OP_W'(c_OP_RTYPE)) || (Op == OP_W'(c_OP_BEQ))  ||
                        (Op == OP_W'(c_OP_ADDI))  || (Op == OP_W'(c_OP_J));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if      (Op == OP_W'(c_OP_LW) || Op == OP_W'(c_OP_SW)) w_next = S_MEMADR;
                else if (Op == OP_W'(c_OP_RTYPE))                      w_next = S_EXECUTE;
                else if (Op == OP_W'(c_OP_BEQ))                        w_next = S_BRANCH;
                else if (Op == OP_W'(c_OP_ADDI))                       w_next = S_ADDIEX;
                else if (Op == OP_W'(c_OP_J))                          w_next = S_JUMP;
                else                                                   w_next = S_FETCH;
            end
            S_MEMADR: begin
                if      (Op == OP_W'(c_OP_LW)) w_next = S_MEMRD;
                else if (Op == OP_W'(c_OP_SW)) w_next = S_MEMWR;
                else                           w_next = S_FETCH;
            end
            S_MEMRD:   w_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && !w_op_known) begin
                r_illegal <= 1'b1;
            end
        end
    end

    mc_output_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (MemReady),
        .i_rst       (RST),
        .o_ctrl      (w_ctrl)
    );

    assign IorD      = w_ctrl.iord;
    assign IRWrite   = w_ctrl.ir_write;
    assign MemWrite  = w_ctrl.mem_write;
    assign MemRead   = w_ctrl.mem_read;
    assign RegWrite  = w_ctrl.reg_write;
    assign RegDst    = w_ctrl.reg_dst;
    assign MemtoReg  = w_ctrl.mem_to_reg;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ALUOp     = w_ctrl.alu_op;
    assign PCSrc     = w_ctrl.pc_src;
    assign PCWrite   = w_ctrl.pc_write;
    assign Branch    = w_ctrl.branch;
    assign IllegalOp = r_illegal;
    assign StateOut  = STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed cycle-by-cycle vector bench for multicycle_control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       CLK;
    logic       RST;
    logic [5:0] Op;
    logic       MemReady;
    logic       IorD, IRWrite, MemWrite, MemRead, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, Branch, IllegalOp;
    logic [3:0] StateOut;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.OP_W(6), .STATE_W(4)) dut (
        .CLK(CLK), .RST(RST), .Op(Op), .MemReady(MemReady),
        .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
        .Branch(Branch), .IllegalOp(IllegalOp), .StateOut(StateOut)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Field order: IorD IRWrite MemWrite MemRead RegWrite RegDst MemtoReg ALUSrcA ALUSrcB ALUOp PCSrc PCWrite Branch
    function automatic logic [15:0] mk(input logic iord, input logic irw, input logic mw, input logic mr,
                                       input logic rw, input logic rd, input logic m2r, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] pcs,
                                       input logic pcw, input logic br);
        return {iord, irw, mw, mr, rw, rd, m2r, asa, asb, aop, pcs, pcw, br};
    endfunction

    localparam logic [15:0] E_FETCH_RDY  = mk(0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0);
    localparam logic [15:0] E_FETCH_WAIT = mk(0,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    localparam logic [15:0] E_FETCH_RST  = mk(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    localparam logic [15:0] E_DECODE     = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    localparam logic [15:0] E_MEMADR     = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    localparam logic [15:0] E_MEMRD      = mk(1,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [15:0] E_MEMRD_RST  = mk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [15:0] E_MEMWB      = mk(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [15:0] E_MEMWR      = mk(1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [15:0] E_MEMWR_RST  = mk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [15:0] E_EXECUTE    = mk(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    localparam logic [15:0] E_ALUWB      = mk(0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [15:0] E_BRANCH     = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1);
    localparam logic [15:0] E_ADDIEX     = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    localparam logic [15:0] E_ADDIWB     = mk(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [15:0] E_JUMP       = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);

    typedef struct {
        logic        rst;
        logic        mr;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [15:0] cw;
        logic        ill;
    } vec_t;

    vec_t vq[$];

    function automatic logic [15:0] actual_cw();
        return {IorD, IRWrite, MemWrite, MemRead, RegWrite, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic mr, input logic [5:0] op,
                       input logic [3:0] st, input logic [15:0] cw, input logic ill);
        vec_t v;
        v.rst = rst; v.mr = mr; v.op = op; v.st = st; v.cw = cw; v.ill = ill;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic mr, input logic [5:0] op);
        RST = rst; MemReady = mr; Op = op;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset, then LW with MemReady tied high
        add(1,1,6'h23, 4'd0,  E_FETCH_RST, 0);
        add(0,1,6'h23, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h23, 4'd1,  E_DECODE,    0);
        add(0,1,6'h23, 4'd2,  E_MEMADR,    0);
        add(0,1,6'h23, 4'd3,  E_MEMRD,     0);
        add(0,1,6'h23, 4'd4,  E_MEMWB,     0);
        // SW with three stall cycles in MEMWR
        add(0,1,6'h2B, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h2B, 4'd1,  E_DECODE,    0);
        add(0,1,6'h2B, 4'd2,  E_MEMADR,    0);
        add(0,0,6'h2B, 4'd5,  E_MEMWR,     0);
        add(0,0,6'h2B, 4'd5,  E_MEMWR,     0);
        add(0,0,6'h2B, 4'd5,  E_MEMWR,     0);
        add(0,1,6'h2B, 4'd5,  E_MEMWR,     0);
        // Fetch stall, then BEQ
        add(0,0,6'h04, 4'd0,  E_FETCH_WAIT,0);
        add(0,1,6'h04, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h04, 4'd1,  E_DECODE,    0);
        add(0,1,6'h04, 4'd8,  E_BRANCH,    0);
        // J
        add(0,1,6'h02, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h02, 4'd1,  E_DECODE,    0);
        add(0,1,6'h02, 4'd11, E_JUMP,      0);
        // R-type
        add(0,1,6'h00, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h00, 4'd1,  E_DECODE,    0);
        add(0,1,6'h00, 4'd6,  E_EXECUTE,   0);
        add(0,1,6'h00, 4'd7,  E_ALUWB,     0);
        // ADDI
        add(0,1,6'h08, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h08, 4'd1,  E_DECODE,    0);
        add(0,1,6'h08, 4'd9,  E_ADDIEX,    0);
        add(0,1,6'h08, 4'd10, E_ADDIWB,    0);
        // Illegal opcode: flag sets after DECODE and stays through the next LW
        add(0,1,6'h3F, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h3F, 4'd1,  E_DECODE,    0);
        add(0,1,6'h23, 4'd0,  E_FETCH_RDY, 1);
        add(0,1,6'h23, 4'd1,  E_DECODE,    1);
        add(0,1,6'h23, 4'd2,  E_MEMADR,    1);
        add(0,0,6'h23, 4'd3,  E_MEMRD,     1);
        // Reset during MEMRD stall: no RegWrite, back to FETCH, flag cleared
        add(1,0,6'h23, 4'd3,  E_MEMRD_RST, 1);
        add(0,1,6'h00, 4'd0,  E_FETCH_RDY, 0);
        add(0,1,6'h00, 4'd1,  E_DECODE,    0);
        add(0,1,6'h00, 4'd6,  E_EXECUTE,   0);

        drive(1'b1, 1'b1, 6'h00);
        next_cycle();

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].mr, vq[i].op);
            @(negedge CLK);
            check("state",   i, {12'd0, StateOut}, {12'd0, vq[i].st});
            check("ctrl",    i, actual_cw(),       vq[i].cw);
            check("illegal", i, {15'd0, IllegalOp}, {15'd0, vq[i].ill});
            next_cycle();
        end

        // Reset asserted mid MEMWR stall must suppress MemWrite and return to FETCH
        drive(1'b0, 1'b1, 6'h2B);
        @(negedge CLK);
        check("seq_aluwb", 100, {12'd0, StateOut}, 16'd7);
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        drive(1'b0, 1'b0, 6'h2B);
        @(negedge CLK);
        check("seq_memwr_stall", 101, actual_cw(), E_MEMWR);
        next_cycle();
        drive(1'b1, 1'b0, 6'h2B);
        @(negedge CLK);
        check("seq_memwr_rst_state", 102, {12'd0, StateOut}, 16'd5);
        check("seq_memwr_rst_ctrl",  103, actual_cw(), E_MEMWR_RST);
        next_cycle();
        drive(1'b0, 1'b0, 6'h2B);
        @(negedge CLK);
        check("seq_after_rst_state", 104, {12'd0, StateOut}, 16'd0);
        check("seq_after_rst_ctrl",  105, actual_cw(), E_FETCH_WAIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
